mydffe_shreg: RTL and testbench

- Parametrised successor to the team's single-bit enable flip-flop: a WIDTH-bit register bank with a shared enable and active-low clear.
- Four modes: hold, parallel load, shift left, shift right.
- A saturating fill counter and full flag track how many serial bits have been accumulated.
- Used by the Morse path to accumulate dot/dash symbols serially, and as a general-purpose enabled register elsewhere.

---
 rtl/mydffe_shreg.sv | 89 ++++++++
 tb/tb_mydffe_shreg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mydffe_shreg.sv
// WIDTH-bit enabled register bank with load and left/right shifting.
// A saturating fill count and full flag track how many serial bits have arrived.
module mydffe_shreg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             sclr,
  input  logic             prn,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    count,
  output logic             full
);

  typedef enum logic [1:0] {
    ModeHold  = 2'b00,
    ModeLoad  = 2'b01,
    ModeLeft  = 2'b10,
    ModeRight = 2'b11
  } mode_e;

  localparam logic [CW-1:0] FullCount = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    count_inc;

  // Saturate rather than wrap once every bit of the bank holds serial data.
  assign count_inc = (count_q == FullCount) ? count_q : count_q + CW'(1);

  always_comb begin
    q_d     = q_q;
    sout_d  = sout_q;
    count_d = count_q;
    if (sclr) begin
      q_d     = RESET_VAL;
      sout_d  = 1'b0;
      count_d = '0;
    end else if (!prn) begin
      q_d     = '1;
      count_d = FullCount;
    end else if (ena) begin
      case (mode_e'(mode))
        ModeHold: ;
        ModeLoad: begin
          q_d     = d;
          count_d = FullCount;
        end
        ModeLeft: begin
          q_d     = {q_q[WIDTH-2:0], sin};
          sout_d  = q_q[WIDTH-1];
          count_d = count_inc;
        end
        ModeRight: begin
          q_d     = {sin, q_q[WIDTH-1:1]};
          sout_d  = q_q[0];
          count_d = count_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      sout_q  <= sout_d;
      count_q <= count_d;
    end
  end

  assign q     = q_q;
  assign sout  = sout_q;
  assign count = count_q;
  assign full  = (count_q == FullCount);

endmodule

// File: tb/tb_mydffe_shreg.sv
// Randomised bench for mydffe_shreg with a behavioural model and directed literal checks.
module tb_mydffe_shreg;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] RV = 8'hA5;

  logic             clk = 1'b0;
  logic             clrn, sclr, prn, ena, sin;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CW-1:0]    count;
  logic             full;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Reference state, plain integers
  int m_q     = 'hA5;
  int m_sout  = 0;
  int m_count = 0;

  mydffe_shreg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk(clk), .clrn(clrn), .sclr(sclr), .prn(prn), .ena(ena), .mode(mode),
    .d(d), .sin(sin), .q(q), .sout(sout), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge clrn) begin
    int old_q;
    old_q = m_q;
    if (!clrn) begin
      m_q = RV; m_sout = 0; m_count = 0;
    end else if (sclr) begin
      m_q = RV; m_sout = 0; m_count = 0;
    end else if (!prn) begin
      m_q = 255; m_count = WIDTH;
    end else if (ena) begin
      if (mode == 2'd1) begin
        m_q = d; m_count = WIDTH;
      end else if (mode == 2'd2) begin
        m_q = ((old_q * 2) + sin) % 256;
        m_sout = old_q / 128;
        m_count = (m_count + 1 > WIDTH) ? WIDTH : m_count + 1;
      end else if (mode == 2'd3) begin
        m_q = (old_q / 2) + (sin * 128);
        m_sout = old_q % 2;
        m_count = (m_count + 1 > WIDTH) ? WIDTH : m_count + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_q", int'(q), m_q);
      chk("model_sout", int'(sout), m_sout);
      chk("model_count", int'(count), m_count);
      chk("model_full", int'(full), (m_count == WIDTH) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0; sclr = 1'b0; prn = 1'b1; ena = 1'b0; mode = 2'd0; d = '0; sin = 1'b0;
    #12 clrn = 1'b1;
    cmp_on = 1'b1;
    chk("reset_q", int'(q), 'hA5);
    chk("reset_count", int'(count), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_sout", int'(sout), 0);

    // Parallel load, then enable low blocks a shift mode
    ena = 1'b1; mode = 2'd1; d = 8'h3C; tick();
    chk("load_q", int'(q), 'h3C);
    chk("load_count", int'(count), 8);
    chk("load_full", int'(full), 1);
    ena = 1'b0; mode = 2'd2; sin = 1'b1;
    repeat (3) tick();
    chk("ena_low_q", int'(q), 'h3C);

    // Asynchronous clear between edges
    #2 clrn = 1'b0;
    #1;
    chk("async_q", int'(q), 'hA5);
    chk("async_count", int'(count), 0);
    chk("async_full", int'(full), 0);
    chk("async_sout", int'(sout), 0);
    tick();
    clrn = 1'b1;

    // sclr then four left shifts of 1,0,1,1 into 8'hA5
    sclr = 1'b1; tick(); sclr = 1'b0;
    ena = 1'b1; mode = 2'd2;
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b1; tick();
    chk("shl4_q", int'(q), 'h5B);
    chk("shl4_count", int'(count), 4);
    chk("shl4_full", int'(full), 0);
    chk("shl4_sout", int'(sout), 0);

    // Right then left shift round trip
    mode = 2'd1; d = 8'h81; tick();
    mode = 2'd3; sin = 1'b0; tick();
    chk("shr_q", int'(q), 'h40);
    chk("shr_sout", int'(sout), 1);
    mode = 2'd2; sin = 1'b1; tick();
    chk("shl_q", int'(q), 'h81);
    chk("shl_sout", int'(sout), 0);

    // Saturation over ten shifts
    sclr = 1'b1; tick(); sclr = 1'b0;
    mode = 2'd2;
    for (int i = 1; i <= 10; i++) begin
      sin = 1'($urandom_range(0, 1));
      tick();
      chk("sat_count", int'(count), (i > 8) ? 8 : i);
      chk("sat_full", int'(full), (i >= 8) ? 1 : 0);
    end

    // sclr beats prn, then prn alone presets
    ena = 1'b0; sclr = 1'b1; prn = 1'b0; tick();
    chk("sclr_prn_q", int'(q), 'hA5);
    chk("sclr_prn_count", int'(count), 0);
    sclr = 1'b0; tick();
    chk("prn_q", int'(q), 'hFF);
    chk("prn_count", int'(count), 8);
    prn = 1'b1;

    // Random traffic with occasional mid-cycle clears
    for (int i = 0; i < 600; i++) begin
      clrn = 1'b1;
      sclr = ($urandom_range(0, 99) < 4);
      prn  = !($urandom_range(0, 99) < 4);
      ena  = ($urandom_range(0, 99) < 80);
      mode = 2'($urandom_range(0, 3));
      d    = 8'($urandom);
      sin  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) begin
        #2 clrn = 1'b0;
      end
      tick();
    end
    clrn = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
